// File: rtl/sr_frame_receiver_pkg.sv
// Shared types and constants for the 7-segment shift-register frame receiver.
// Segment byte layout is {dp,g,f,e,d,c,b,a}, active-high.
package sr_frame_receiver_pkg;

    function automatic int frame_bits(input int digits);
        return 8 * digits;
    endfunction

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_R     = 7'h50;

    localparam logic [4:0] CODE_BLANK = 5'h10;
    localparam logic [4:0] CODE_MINUS = 5'h11;
    localparam logic [4:0] CODE_R     = 5'h12;
    localparam logic [4:0] CODE_BAD   = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK
    } state_t;

endpackage

// File: rtl/sr_frame_receiver_seg7_decoder.sv
// Maps one segment byte to a digit code; the decimal point does not
// take part in the decode.
module seg7_decoder
    import sr_frame_receiver_pkg::*;
(
    input  logic [7:0] segs,
    output logic [4:0] code
);

    logic unused_dp;
    assign unused_dp = segs[7];

    always_comb begin
        code = CODE_BAD;
        if (segs[6:0] == SEG_BLANK) begin
            code = CODE_BLANK;
        end else if (segs[6:0] == SEG_MINUS) begin
            code = CODE_MINUS;
        end else if (segs[6:0] == SEG_R) begin
            code = CODE_R;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (segs[6:0] == HEX_GLYPH[i]) begin
                    code = 5'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sr_frame_receiver.sv
// Receives one serial 7-segment frame, checks its length, decodes every
// digit and presents the result on a valid/ready port.
module sr_frame_receiver
    import sr_frame_receiver_pkg::*;
#(
    parameter int NUM_7_SEG_DISPLAYS = 5,
    parameter int SYNC_STAGES        = 2,
    localparam int FRAME_BITS        = frame_bits(NUM_7_SEG_DISPLAYS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_sr_data,
    input  logic                            i_sr_clk,
    input  logic                            i_sr_oe_n,
    output logic [FRAME_BITS-1:0]           o_frame_data,
    output logic [5*NUM_7_SEG_DISPLAYS-1:0] o_digit_codes,
    output logic                            o_frame_valid,
    input  logic                            i_frame_ready,
    output logic                            o_frame_error,
    output logic                            o_overrun
);

    localparam int CW = $clog2(FRAME_BITS + 2);

    logic [2:0]            raw;
    logic [2:0]            synced;
    logic [2:1]            hist;
    logic                  clk_rise;
    logic                  oe_rise;
    logic                  oe_fall;
    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         count;
    logic [FRAME_BITS-1:0] shreg;
    logic [5*NUM_7_SEG_DISPLAYS-1:0] codes_dec;
    logic                  shift_en;
    logic                  clear_cnt;
    logic                  idle_clk;
    logic                  check;
    logic                  good;
    logic                  load;

    assign raw = {i_sr_oe_n, i_sr_clk, i_sr_data};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign synced = raw;
        end else begin : g_sync
            logic [2:0] pipe [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= raw;
                    for (int k = 1; k < SYNC_STAGES; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign synced = pipe[SYNC_STAGES-1];
        end
    endgenerate

    assign clk_rise = synced[1] & ~hist[1];
    assign oe_rise  = synced[2] & ~hist[2];
    assign oe_fall  = ~synced[2] & hist[2];

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        clear_cnt = 1'b0;
        idle_clk  = 1'b0;
        check     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                idle_clk = clk_rise;
                if (oe_rise) begin
                    state_nxt = ST_SHIFT;
                    clear_cnt = 1'b1;
                end
            end
            ST_SHIFT: begin
                shift_en = clk_rise;
                if (oe_fall) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                check     = 1'b1;
                state_nxt = oe_rise ? ST_SHIFT : ST_IDLE;
                clear_cnt = oe_rise;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign good = check && (count == CW'(FRAME_BITS));
    assign load = good && (!o_frame_valid || i_frame_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    generate
        for (genvar g = 0; g < NUM_7_SEG_DISPLAYS; g++) begin : g_dec
            seg7_decoder u_dec (
                .segs (shreg[8*g +: 8]),
                .code (codes_dec[5*g +: 5])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist          <= '0;
            count         <= '0;
            shreg         <= '0;
            o_frame_data  <= '0;
            o_digit_codes <= '0;
            o_frame_valid <= 1'b0;
            o_frame_error <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            hist <= synced[2:1];
            if (clear_cnt) begin
                count <= '0;
            end else if (shift_en && count != CW'(FRAME_BITS + 1)) begin
                count <= count + 1'b1;
            end
            if (shift_en) shreg <= {shreg[FRAME_BITS-2:0], synced[0]};
            o_frame_error <= idle_clk || (check && !good);
            // A completing frame during a transfer reloads, keeping valid high
            if (load) begin
                o_frame_data  <= shreg;
                o_digit_codes <= codes_dec;
                o_frame_valid <= 1'b1;
            end else if (o_frame_valid && i_frame_ready) begin
                o_frame_valid <= 1'b0;
            end
            if (good && o_frame_valid && !i_frame_ready) o_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sr_frame_receiver.sv
// Directed bench for sr_frame_receiver: serial frames in, decoded
// frames, error pulses and overrun flag checked against fixed values.
module tb_sr_frame_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sr_data;
    logic        sr_clk;
    logic        sr_oe_n;
    logic [39:0] frame_data;
    logic [24:0] digit_codes;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_error;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int err_cnt  = 0;
    int vld_cnt  = 0;
    logic [39:0] last_data  = '0;
    logic [24:0] last_codes = '0;

    localparam logic [63:0] FR_HEX   = 64'h065B4F666D;
    localparam logic [63:0] FR_MINUS = 64'h4006790000;
    localparam logic [63:0] FR_HI    = 64'h7F6F777C39;
    localparam logic [63:0] FR_MISC  = 64'hBF12508000;

    sr_frame_receiver #(
        .NUM_7_SEG_DISPLAYS (5),
        .SYNC_STAGES        (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sr_data     (sr_data),
        .i_sr_clk      (sr_clk),
        .i_sr_oe_n     (sr_oe_n),
        .o_frame_data  (frame_data),
        .o_digit_codes (digit_codes),
        .o_frame_valid (frame_valid),
        .i_frame_ready (frame_ready),
        .o_frame_error (frame_error),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) vld_cnt++;
        if (frame_error) err_cnt++;
        if (frame_valid && frame_ready) begin
            xfer_cnt++;
            last_data  = frame_data;
            last_codes = digit_codes;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic shift_bit(input logic b);
        sr_data = b;
        tick(2);
        sr_clk = 1'b1;
        tick(3);
        sr_clk = 1'b0;
        tick(2);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        sr_oe_n = 1'b1;
        tick(3);
        for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic end_frame();
        sr_oe_n = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        sr_data     = 1'b0;
        sr_clk      = 1'b0;
        sr_oe_n     = 1'b0;
        frame_ready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %0b want 0", frame_valid);
        end
        n_checks++;
        if (frame_data !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", frame_data);
        end
        n_checks++;
        if (digit_codes !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_codes got %h want 0", digit_codes);
        end
        n_checks++;
        if (frame_error !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got err=%0b ovr=%0b want 0 0",
                     frame_error, overrun);
        end
    endtask

    task automatic test_hex_frame();
        int x0, v0, e0, lat;
        x0 = xfer_cnt;
        v0 = vld_cnt;
        e0 = err_cnt;
        lat = 0;
        send_bits(FR_HEX, 40);
        sr_oe_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid && lat == 0) lat = k;
        end
        tick(2);
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL hex_latency got %0d want 4", lat);
        end
        n_checks++;
        if (xfer_cnt - x0 != 1 || vld_cnt - v0 != 1) begin
            n_fail++;
            $display("FAIL hex_xfer got xfers=%0d valid_cycles=%0d want 1 1",
                     xfer_cnt - x0, vld_cnt - v0);
        end
        n_checks++;
        if (last_data !== 40'h065B4F666D) begin
            n_fail++;
            $display("FAIL hex_data got %h want 065b4f666d", last_data);
        end
        n_checks++;
        if (last_codes !== {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}) begin
            n_fail++;
            $display("FAIL hex_codes got %h want %h", last_codes,
                     {5'd1, 5'd2, 5'd3, 5'd4, 5'd5});
        end
        n_checks++;
        if (err_cnt != e0) begin
            n_fail++;
            $display("FAIL hex_err got %0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_glyphs(input logic [63:0] v, input logic [24:0] want,
                               input string name);
        int x0;
        x0 = xfer_cnt;
        send_bits(v, 40);
        end_frame();
        n_checks++;
        if (xfer_cnt - x0 != 1 || last_data !== v[39:0]) begin
            n_fail++;
            $display("FAIL %s_data got n=%0d %h want 1 %h", name,
                     xfer_cnt - x0, last_data, v[39:0]);
        end
        n_checks++;
        if (last_codes !== want) begin
            n_fail++;
            $display("FAIL %s_codes got %h want %h", name, last_codes, want);
        end
    endtask

    task automatic test_bad_length(input int n);
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        send_bits(FR_HEX, n);
        end_frame();
        n_checks++;
        if (err_cnt - e0 != 1) begin
            n_fail++;
            $display("FAIL len%0d_err got %0d cycles want 1", n, err_cnt - e0);
        end
        n_checks++;
        if (vld_cnt != v0 || frame_data !== FR_MISC[39:0]) begin
            n_fail++;
            $display("FAIL len%0d_hold got valid_cycles=%0d data=%h want 0 %h",
                     n, vld_cnt - v0, frame_data, FR_MISC[39:0]);
        end
    endtask

    task automatic test_overrun();
        int x0;
        frame_ready = 1'b0;
        send_bits(FR_HEX, 40);
        end_frame();
        n_checks++;
        if (frame_valid !== 1'b1 || frame_data !== FR_HEX[39:0]) begin
            n_fail++;
            $display("FAIL ovr_first got v=%0b %h want 1 %h",
                     frame_valid, frame_data, FR_HEX[39:0]);
        end
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_early got %0b want 0", overrun);
        end
        send_bits(FR_MINUS, 40);
        end_frame();
        n_checks++;
        if (frame_valid !== 1'b1 || frame_data !== FR_HEX[39:0] ||
            digit_codes !== {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}) begin
            n_fail++;
            $display("FAIL ovr_hold got v=%0b %h %h want 1 %h",
                     frame_valid, frame_data, digit_codes, FR_HEX[39:0]);
        end
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_flag got %0b want 1", overrun);
        end
        x0 = xfer_cnt;
        frame_ready = 1'b1;
        tick(4);
        n_checks++;
        if (xfer_cnt - x0 != 1 || last_data !== FR_HEX[39:0] ||
            frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_take got n=%0d %h v=%0b want 1 %h 0",
                     xfer_cnt - x0, last_data, frame_valid, FR_HEX[39:0]);
        end
    endtask

    task automatic test_mid_reset();
        int x0, e0;
        sr_oe_n = 1'b1;
        tick(3);
        for (int i = 39; i >= 20; i--) shift_bit(FR_HI[i]);
        rst_n   = 1'b0;
        sr_oe_n = 1'b0;
        sr_clk  = 1'b0;
        tick(3);
        n_checks++;
        if (frame_valid !== 1'b0 || overrun !== 1'b0 || frame_data !== 40'h0) begin
            n_fail++;
            $display("FAIL mid_reset got v=%0b ovr=%0b %h want 0 0 0",
                     frame_valid, overrun, frame_data);
        end
        rst_n = 1'b1;
        tick(3);
        x0 = xfer_cnt;
        e0 = err_cnt;
        send_bits(FR_HEX, 40);
        end_frame();
        n_checks++;
        if (xfer_cnt - x0 != 1 || last_data !== FR_HEX[39:0] || err_cnt != e0) begin
            n_fail++;
            $display("FAIL mid_frame got n=%0d %h err=%0d want 1 %h 0",
                     xfer_cnt - x0, last_data, err_cnt - e0, FR_HEX[39:0]);
        end
    endtask

    task automatic test_coincident();
        int x0, e0;
        x0 = xfer_cnt;
        e0 = err_cnt;
        sr_oe_n = 1'b1;
        tick(3);
        for (int i = 39; i >= 1; i--) shift_bit(FR_HI[i]);
        sr_data = FR_HI[0];
        tick(2);
        sr_clk  = 1'b1;
        sr_oe_n = 1'b0;
        tick(3);
        sr_clk = 1'b0;
        tick(10);
        n_checks++;
        if (xfer_cnt - x0 != 1 || last_data !== FR_HI[39:0] || err_cnt != e0) begin
            n_fail++;
            $display("FAIL coinc_frame got n=%0d %h err=%0d want 1 %h 0",
                     xfer_cnt - x0, last_data, err_cnt - e0, FR_HI[39:0]);
        end
        n_checks++;
        if (last_codes !== {5'h8, 5'h9, 5'hA, 5'hB, 5'hC}) begin
            n_fail++;
            $display("FAIL coinc_codes got %h want %h", last_codes,
                     {5'h8, 5'h9, 5'hA, 5'hB, 5'hC});
        end
    endtask

    task automatic test_idle_pulse();
        int x0, e0;
        x0 = xfer_cnt;
        e0 = err_cnt;
        sr_clk = 1'b1;
        tick(3);
        sr_clk = 1'b0;
        tick(6);
        n_checks++;
        if (err_cnt - e0 != 1 || xfer_cnt != x0) begin
            n_fail++;
            $display("FAIL idle_pulse got err=%0d xfer=%0d want 1 0",
                     err_cnt - e0, xfer_cnt - x0);
        end
    endtask

    initial begin
        test_reset();
        test_hex_frame();
        test_glyphs(FR_MINUS, {5'h11, 5'h01, 5'h0E, 5'h10, 5'h10}, "minus");
        test_glyphs(FR_MISC, {5'h00, 5'h1F, 5'h12, 5'h10, 5'h10}, "misc");
        test_bad_length(39);
        test_bad_length(41);
        test_overrun();
        test_mid_reset();
        test_coincident();
        test_idle_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
